// File: rtl/mem_line_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_line_responder : line store with fixed-latency, in-order, credit-limited
// read responses for the cache-cluster memory bus.            Rev 1.0
// ----------------------------------------------------------------------------
module mem_line_responder #(
  parameter int LINE_SIZE  = 64,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4,
  parameter int RSP_QUEUE  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_rw,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [LINE_SIZE-1:0]   req_byteen,
  input  logic [8*LINE_SIZE-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [8*LINE_SIZE-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]   rsp_tag,
  input  logic                   rsp_ready,
  output logic [31:0]            perf_reads,
  output logic [31:0]            perf_writes
);

  localparam int DATA_W  = 8 * LINE_SIZE;
  localparam int ENTRY_W = DATA_W + TAG_WIDTH;
  localparam int CNT_W   = $clog2(RSP_QUEUE + 1);
  localparam int PTR_W   = (RSP_QUEUE > 1) ? $clog2(RSP_QUEUE) : 1;
  localparam logic [CNT_W-1:0] C_QUEUE_FULL = CNT_W'(RSP_QUEUE);
  localparam logic [PTR_W-1:0] C_PTR_LAST   = PTR_W'(RSP_QUEUE - 1);

  logic                  req_fire;
  logic                  rd_fire;
  logic                  wr_fire;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DATA_W-1:0]     rd_line;

  logic [DATA_W-1:0]     store_q [2**DEPTH_LOG2];

  logic [LATENCY-1:0]    pipe_v_q, pipe_v_d;
  logic [ENTRY_W-1:0]    pipe_e_q [LATENCY];
  logic [ENTRY_W-1:0]    pipe_e_d [LATENCY];

  logic [ENTRY_W-1:0]    q_mem_q [RSP_QUEUE];
  logic [PTR_W-1:0]      q_wr_q, q_wr_d;
  logic [PTR_W-1:0]      q_rd_q, q_rd_d;
  logic [CNT_W-1:0]      q_cnt_q, q_cnt_d;
  logic [ENTRY_W-1:0]    q_head;
  logic                  q_full;
  logic                  push;
  logic                  pop;
  logic                  stall;

  logic [CNT_W-1:0]      credits_q, credits_d;
  logic [31:0]           perf_reads_q, perf_reads_d;
  logic [31:0]           perf_writes_q, perf_writes_d;

  assign idx      = req_addr[DEPTH_LOG2-1:0];
  assign req_fire = req_valid && req_ready;
  assign rd_fire  = req_fire && !req_rw;
  assign wr_fire  = req_fire && req_rw;

  // Upper address bits alias onto the same lines by design.
  if (ADDR_WIDTH > DEPTH_LOG2) begin : g_unused_addr
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:DEPTH_LOG2];
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < LINE_SIZE; i++) begin
        if (req_byteen[i]) begin
          store_q[idx][8*i +: 8] <= req_data[8*i +: 8];
        end
      end
    end
  end

  // One request per cycle, so every earlier write has already landed here.
  assign rd_line = store_q[idx];

  assign q_full = (q_cnt_q == C_QUEUE_FULL);
  assign pop    = rsp_valid && rsp_ready;
  assign push   = pipe_v_q[LATENCY-1] && (!q_full || pop);
  assign stall  = pipe_v_q[LATENCY-1] && !push;

  always_comb begin
    pipe_v_d[0] = rd_fire;
    pipe_e_d[0] = {req_tag, rd_line};
    for (int i = 1; i < LATENCY; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_e_d[i] = pipe_e_q[i-1];
    end
    if (stall) begin
      pipe_v_d[LATENCY-1] = 1'b1;
      pipe_e_d[LATENCY-1] = pipe_e_q[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v_q <= '0;
    end else begin
      pipe_v_q <= pipe_v_d;
    end
  end

  always_ff @(posedge clk) begin
    pipe_e_q <= pipe_e_d;
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    q_wr_d  = push ? ptr_inc(q_wr_q) : q_wr_q;
    q_rd_d  = pop  ? ptr_inc(q_rd_q) : q_rd_q;
    q_cnt_d = q_cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_wr_q  <= '0;
      q_rd_q  <= '0;
      q_cnt_q <= '0;
    end else begin
      q_wr_q  <= q_wr_d;
      q_rd_q  <= q_rd_d;
      q_cnt_q <= q_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem_q[q_wr_q] <= pipe_e_q[LATENCY-1];
    end
  end

  assign q_head    = q_mem_q[q_rd_q];
  assign rsp_valid = (q_cnt_q != '0);
  assign rsp_data  = rsp_valid ? q_head[DATA_W-1:0] : '0;
  assign rsp_tag   = rsp_valid ? q_head[ENTRY_W-1:DATA_W] : '0;

  // A credit is held by every read from acceptance until its response pops.
  always_comb begin
    credits_d = credits_q;
    if (rd_fire && !pop) begin
      credits_d = credits_q - CNT_W'(1);
    end else if (pop && !rd_fire) begin
      credits_d = credits_q + CNT_W'(1);
    end
    perf_reads_d  = perf_reads_q  + 32'(rd_fire);
    perf_writes_d = perf_writes_q + 32'(wr_fire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q     <= C_QUEUE_FULL;
      perf_reads_q  <= '0;
      perf_writes_q <= '0;
    end else begin
      credits_q     <= credits_d;
      perf_reads_q  <= perf_reads_d;
      perf_writes_q <= perf_writes_d;
    end
  end

  assign req_ready   = (credits_q != '0);
  assign perf_reads  = perf_reads_q;
  assign perf_writes = perf_writes_q;

  int occupancy;
  always_comb begin
    occupancy = $countones(pipe_v_q) + int'(q_cnt_q);
  end

  a_no_overcommit: assert property (@(posedge clk) disable iff (reset)
    occupancy <= RSP_QUEUE);
  a_no_final_stall: assert property (@(posedge clk) disable iff (reset)
    !stall);
  a_credit_range: assert property (@(posedge clk) disable iff (reset)
    credits_q <= C_QUEUE_FULL);
  a_req_valid_known: assert property (@(posedge clk)
    !reset |-> !$isunknown(req_valid));

endmodule
`default_nettype wire

// File: tb/tb_mem_line_responder.sv
`default_nettype none
// tb_mem_line_responder : directed self-checking bench for mem_line_responder.
module tb_mem_line_responder;

  localparam int LINE_SIZE  = 64;
  localparam int ADDR_WIDTH = 26;
  localparam int TAG_WIDTH  = 8;
  localparam int DEPTH_LOG2 = 8;
  localparam int LATENCY    = 4;
  localparam int RSP_QUEUE  = 4;
  localparam int DW         = 8 * LINE_SIZE;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid;
  logic                  req_rw;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LINE_SIZE-1:0]  req_byteen;
  logic [DW-1:0]         req_data;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [DW-1:0]         rsp_data;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic                  rsp_ready;
  logic [31:0]           perf_reads;
  logic [31:0]           perf_writes;

  int checks = 0;
  int errors = 0;

  mem_line_responder #(
    .LINE_SIZE (LINE_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH),
    .TAG_WIDTH (TAG_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2),
    .LATENCY   (LATENCY),
    .RSP_QUEUE (RSP_QUEUE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_byteen (req_byteen),
    .req_data   (req_data),
    .req_tag    (req_tag),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_ready  (rsp_ready),
    .perf_reads (perf_reads),
    .perf_writes(perf_writes)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Presents one request and returns just after the edge where it fires.
  task automatic send(input logic rw, input logic [ADDR_WIDTH-1:0] addr,
                      input logic [LINE_SIZE-1:0] be, input logic [DW-1:0] data,
                      input logic [TAG_WIDTH-1:0] tag);
    int n;
    n          = 0;
    req_valid  = 1'b1;
    req_rw     = rw;
    req_addr   = addr;
    req_byteen = be;
    req_data   = data;
    req_tag    = tag;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("req_accept_timeout", (n < 50), 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Read with rsp_ready=1: checks fire-to-valid latency, data and tag, then pops.
  task automatic read_expect(input string name, input logic [ADDR_WIDTH-1:0] addr,
                             input logic [TAG_WIDTH-1:0] tag, input logic [DW-1:0] exp);
    int n;
    send(1'b0, addr, '0, '0, tag);
    wait_rsp(n);
    chk({name, "_latency"}, n + 1, LATENCY + 1);
    chk({name, "_data"}, rsp_data, exp);
    chk({name, "_tag"}, rsp_tag, tag);
    tick();
  endtask

  initial begin
    logic [DW-1:0]        pat_p;
    logic [DW-1:0]        pat_q;
    logic [DW-1:0]        exp_partial;
    logic [17:0]          fire_pat;
    logic [TAG_WIDTH-1:0] tg;
    logic                 rdy;
    logic                 pop;
    logic                 fire;
    int                   fired;
    int                   got;
    int                   spurious;
    int                   n;

    for (int i = 0; i < LINE_SIZE; i++) begin
      pat_p[8*i +: 8] = 8'(i) ^ 8'hA5;
      pat_q[8*i +: 8] = 8'h3C + 8'(i);
    end
    exp_partial = {{(DW-8){1'b1}}, 8'h5A};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_rw     = 1'b0;
    req_addr   = '0;
    req_byteen = '0;
    req_data   = '0;
    req_tag    = '0;
    rsp_ready  = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_tag", rsp_tag, 0);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_perf_reads", perf_reads, 0);
    chk("reset_perf_writes", perf_writes, 0);

    // Full-line write then read back.
    send(1'b1, 26'h10, '1, pat_p, 8'h00);
    read_expect("full_line", 26'h10, 8'h3A, pat_p);
    chk("full_line_perf_writes", perf_writes, 1);
    chk("full_line_perf_reads", perf_reads, 1);
    chk("full_line_popped", rsp_valid, 0);

    // Byte-enabled merge.
    send(1'b1, 26'h20, '1, '1, 8'h00);
    send(1'b1, 26'h20, LINE_SIZE'(1), DW'(8'h5A), 8'h00);
    read_expect("partial", 26'h20, 8'h55, exp_partial);

    // Back-pressure: only RSP_QUEUE reads may be outstanding.
    rsp_ready = 1'b0;
    fired     = 0;
    for (int c = 0; c < 20; c++) begin
      req_valid = 1'b1;
      req_rw    = 1'b0;
      req_addr  = 26'h10;
      req_tag   = 8'(fired + 1);
      rdy       = req_ready;
      tick();
      if (rdy) fired++;
    end
    chk("bp_fired", fired, RSP_QUEUE);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_head_tag_held", rsp_tag, 1);
    chk("bp_head_data_held", rsp_data, pat_p);

    rsp_ready = 1'b1;
    got       = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      pop  = rsp_valid;
      tg   = rsp_tag;
      fire = req_valid && req_ready;
      tick();
      if (pop) begin
        chk($sformatf("bp_order_%0d", got), tg, got + 1);
        got++;
      end
      if (fire) begin
        fired++;
        if (fired < 6) req_tag = 8'(fired + 1);
        else           req_valid = 1'b0;
      end
    end
    chk("bp_responses", got, 6);
    chk("bp_total_fired", fired, 6);
    spurious = 0;
    repeat (8) begin
      if (rsp_valid) spurious++;
      tick();
    end
    chk("bp_no_extra_rsp", spurious, 0);
    chk("bp_perf_reads", perf_reads, 8);
    chk("bp_perf_writes", perf_writes, 3);

    // Streaming reads: 5-cycle round trip against 4 credits gives a
    // 4-on/2-off acceptance pattern, with fire+pop cycles holding credits.
    fire_pat  = '0;
    fired     = 0;
    got       = 0;
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = 26'h20;
    req_tag   = 8'h80;
    for (int c = 0; c < 18; c++) begin
      pop  = rsp_valid;
      tg   = rsp_tag;
      fire = req_valid && req_ready;
      tick();
      if (pop) begin
        chk($sformatf("stream_order_%0d", got), tg, 8'h80 + 8'(got));
        got++;
      end
      if (fire) begin
        fire_pat[c] = 1'b1;
        fired++;
        if (fired < 12) req_tag = 8'(8'h80 + fired);
        else            req_valid = 1'b0;
      end
    end
    chk("stream_fire_pattern", fire_pat, 18'b001111001111001111);
    for (int c = 0; c < 40 && got < 12; c++) begin
      pop = rsp_valid;
      tg  = rsp_tag;
      tick();
      if (pop) begin
        chk($sformatf("stream_order_%0d", got), tg, 8'h80 + 8'(got));
        got++;
      end
    end
    chk("stream_responses", got, 12);

    // Address aliasing modulo the store depth.
    send(1'b1, 26'h100, '1, pat_q, 8'h00);
    read_expect("alias", 26'h000, 8'h77, pat_q);

    // Reset with reads in flight.
    send(1'b0, 26'h10, '0, '0, 8'h01);
    send(1'b0, 26'h10, '0, '0, 8'h02);
    send(1'b0, 26'h10, '0, '0, 8'h03);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_perf_reads", perf_reads, 0);
    chk("midrst_perf_writes", perf_writes, 0);
    spurious = 0;
    repeat (12) begin
      if (rsp_valid) spurious++;
      tick();
    end
    chk("midrst_no_rsp", spurious, 0);

    rsp_ready = 1'b0;
    fired     = 0;
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = 26'h10;
    req_tag   = 8'h09;
    for (int c = 0; c < 12; c++) begin
      rdy = req_ready;
      tick();
      if (rdy) fired++;
    end
    req_valid = 1'b0;
    chk("midrst_credits", fired, RSP_QUEUE);
    rsp_ready = 1'b1;
    for (int k = 0; k < RSP_QUEUE; k++) begin
      wait_rsp(n);
      chk($sformatf("midrst_rsp_seen_%0d", k), rsp_valid, 1);
      chk($sformatf("midrst_data_%0d", k), rsp_data, pat_p);
      tick();
    end
    chk("midrst_drained", rsp_valid, 0);
    chk("midrst_perf_reads_after", perf_reads, RSP_QUEUE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
